inst_fetch_mem: RTL and testbench

Parametrised instruction memory for the superscalar core. It stores 16-bit IITB-RISC instructions and returns FETCH_WIDTH consecutive instructions per access, starting at any word address. Reads are registered and stallable. A program-load write port and an optional post-reset clear sweep let the bench or a boot loader fill memory at runtime. It sits between the PC/fetch stage and the decode stage.

---
 rtl/inst_fetch_mem.sv | 58 +++++
 tb/tb_inst_fetch_mem.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: instruction memory with multi-slot registered fetch, load port and post-reset clear sweep
module inst_fetch_mem #(
   parameter int          DEPTH          = 256,
   parameter int          ADDR_W         = 16,
   parameter int          FETCH_WIDTH    = 2,
   parameter logic [15:0] NOP_WORD       = 16'hFFFF,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      fetch_en,
   input  logic [ADDR_W-1:0]         fetch_addr,
   input  logic                      fetch_stall,
   output logic [16*FETCH_WIDTH-1:0] inst_bus,
   output logic [FETCH_WIDTH-1:0]    slot_valid,
   output logic                      inst_valid,
   input  logic                      load_en,
   input  logic [ADDR_W-1:0]         load_addr,
   input  logic [15:0]               load_data,
   output logic                      ready
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
   typedef enum logic {CLEAR, READY} state_t;
   state_t state, state_d;
   logic [AW-1:0] cnt;
   logic [15:0] mem [DEPTH];
   logic [16*FETCH_WIDTH-1:0] rd_bus;
   logic [FETCH_WIDTH-1:0] rd_ok;
   logic take_fetch;
   always_comb state_d = (state == CLEAR && cnt == AW'(DEPTH-1)) ? READY : state;
   always_ff @(posedge clock) begin
      state <= reset ? (CLEAR_ON_RESET ? CLEAR : READY) : state_d;
      cnt   <= reset ? '0 : (state == CLEAR ? cnt + 1'b1 : cnt);
   end
   assign ready      = state == READY;
   assign take_fetch = ready && fetch_en && !load_en;
   always_ff @(posedge clock)
      if (!reset && state == CLEAR) mem[cnt] <= NOP_WORD;
      else if (!reset && ready && load_en && {2'b00, load_addr} < DEPTH_X) mem[load_addr[AW-1:0]] <= load_data;
   genvar i;
   for (i = 0; i < FETCH_WIDTH; i++) begin : g_slot
      logic [ADDR_W+1:0] a;
      assign a                = {2'b00, fetch_addr} + (ADDR_W+2)'(i);
      assign rd_ok[i]         = a < DEPTH_X;
      assign rd_bus[16*i+:16] = rd_ok[i] ? mem[a[AW-1:0]] : NOP_WORD;
   end
   always_ff @(posedge clock)
      if (reset) begin
         inst_bus   <= {FETCH_WIDTH{NOP_WORD}};
         slot_valid <= '0;
         inst_valid <= 1'b0;
      end else if (!fetch_stall) begin
         inst_valid <= take_fetch;
         slot_valid <= take_fetch ? rd_ok : '0;
         if (take_fetch) inst_bus <= rd_bus;
      end
endmodule

// File: tb/tb_inst_fetch_mem.sv
// tb_inst_fetch_mem: directed scoreboard bench for inst_fetch_mem at default parameters
module tb_inst_fetch_mem;
   logic        clock = 1'b0, reset = 1'b1;
   logic        fetch_en = 1'b0, fetch_stall = 1'b0, load_en = 1'b0;
   logic [15:0] fetch_addr = '0, load_addr = '0, load_data = '0;
   logic [31:0] inst_bus;
   logic [1:0]  slot_valid;
   logic        inst_valid, ready;
   typedef struct {
      logic [31:0] bus;
      logic [1:0]  sv;
      logic        iv;
   } exp_t;
   exp_t  sb[$];
   string tags[$];
   int    total = 0, bad = 0;
   int    n;
   inst_fetch_mem dut (
      .clock(clock), .reset(reset), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
      .fetch_stall(fetch_stall), .inst_bus(inst_bus), .slot_valid(slot_valid),
      .inst_valid(inst_valid), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .ready(ready)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic expect_out(input string tag, input logic [31:0] b, input logic [1:0] s, input logic v);
      exp_t e;
      e.bus = b;
      e.sv  = s;
      e.iv  = v;
      sb.push_back(e);
      tags.push_back(tag);
   endtask
   task automatic cyc;
      exp_t  e;
      string t;
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         t = tags.pop_front();
         chk({t, ".bus"}, inst_bus, e.bus);
         chk({t, ".sv"}, 32'(slot_valid), 32'(e.sv));
         chk({t, ".iv"}, 32'(inst_valid), 32'(e.iv));
      end
   endtask
   task automatic drive(input logic fe, input logic [15:0] fa, input logic le,
                        input logic [15:0] la, input logic [15:0] ld, input logic st);
      fetch_en    = fe;
      fetch_addr  = fa;
      load_en     = le;
      load_addr   = la;
      load_data   = ld;
      fetch_stall = st;
   endtask
   initial begin
      expect_out("rst", 32'hFFFF_FFFF, 2'b00, 1'b0);
      cyc;
      chk("rst_ready", 32'(ready), 32'd0);
      reset = 1'b0;
      n = 0;
      while (!ready && n < 1000) begin
         cyc;
         n++;
      end
      chk("sweep_len", n, 256);
      drive(1, 16'h0010, 0, 0, 0, 0);
      expect_out("f10", 32'hFFFF_FFFF, 2'b11, 1'b1);
      cyc;
      drive(0, 0, 1, 16'd1, 16'h4E41, 0);
      expect_out("ld1", 32'hFFFF_FFFF, 2'b00, 1'b0);
      cyc;
      drive(0, 0, 1, 16'd2, 16'h4E80, 0);
      expect_out("ld2", 32'hFFFF_FFFF, 2'b00, 1'b0);
      cyc;
      drive(1, 16'd1, 0, 0, 0, 0);
      expect_out("f1", 32'h4E80_4E41, 2'b11, 1'b1);
      cyc;
      drive(0, 0, 1, 16'd255, 16'h1234, 0);
      expect_out("ld255", 32'h4E80_4E41, 2'b00, 1'b0);
      cyc;
      drive(1, 16'd255, 0, 0, 0, 0);
      expect_out("f255", 32'hFFFF_1234, 2'b01, 1'b1);
      cyc;
      drive(1, 16'h0300, 0, 0, 0, 0);
      expect_out("f300", 32'hFFFF_FFFF, 2'b00, 1'b1);
      cyc;
      drive(0, 0, 1, 16'h0100, 16'hAAAA, 0);
      expect_out("ld_oor", 32'hFFFF_FFFF, 2'b00, 1'b0);
      cyc;
      drive(1, 16'd0, 0, 0, 0, 0);
      expect_out("f0", 32'h4E41_FFFF, 2'b11, 1'b1);
      cyc;
      drive(1, 16'd1, 0, 0, 0, 0);
      expect_out("pre_stall", 32'h4E80_4E41, 2'b11, 1'b1);
      cyc;
      drive(1, 16'd7, 1, 16'd3, 16'h5555, 1);
      expect_out("stall1", 32'h4E80_4E41, 2'b11, 1'b1);
      cyc;
      drive(1, 16'd8, 0, 0, 0, 1);
      expect_out("stall2", 32'h4E80_4E41, 2'b11, 1'b1);
      cyc;
      drive(1, 16'd9, 0, 0, 0, 1);
      expect_out("stall3", 32'h4E80_4E41, 2'b11, 1'b1);
      cyc;
      drive(1, 16'd2, 0, 0, 0, 0);
      expect_out("post_stall", 32'h5555_4E80, 2'b11, 1'b1);
      cyc;
      drive(1, 16'd5, 1, 16'd5, 16'h7777, 0);
      expect_out("ld_fe", 32'h5555_4E80, 2'b00, 1'b0);
      cyc;
      drive(1, 16'd5, 0, 0, 0, 0);
      expect_out("refetch5", 32'hFFFF_7777, 2'b11, 1'b1);
      cyc;
      drive(0, 16'd5, 0, 0, 0, 0);
      expect_out("idle", 32'hFFFF_7777, 2'b00, 1'b0);
      cyc;
      reset = 1'b1;
      expect_out("rst2", 32'hFFFF_FFFF, 2'b00, 1'b0);
      cyc;
      reset = 1'b0;
      repeat (100) cyc;
      chk("mid_sweep_ready", 32'(ready), 32'd0);
      reset = 1'b1;
      cyc;
      reset = 1'b0;
      n = 0;
      while (!ready && n < 1000) begin
         if (n == 50) drive(0, 0, 1, 16'd10, 16'hBEEF, 0);
         else if (n == 60) drive(1, 16'h0010, 0, 0, 0, 0);
         else drive(0, 0, 0, 0, 0, 0);
         cyc;
         n++;
         if (n == 61) chk("clr_fetch_iv", 32'(inst_valid), 32'd0);
      end
      chk("resweep_len", n, 256);
      drive(1, 16'd10, 0, 0, 0, 0);
      expect_out("f10_clr", 32'hFFFF_FFFF, 2'b11, 1'b1);
      cyc;
      drive(1, 16'd1, 0, 0, 0, 0);
      expect_out("f1_clr", 32'hFFFF_FFFF, 2'b11, 1'b1);
      cyc;
      drive(0, 0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
